mdu_iter: RTL and testbench

Iterative multiply/divide unit that extends the single-cycle ALU with the unsigned multiply, multiply-high, divide and remainder operations the ALU cannot compute combinationally. It accepts one operation through a start/busy/done handshake, runs a radix-2 shift-add or shift-subtract loop for WIDTH cycles, then returns a result word and z/v/n flags. The flag semantics match the ALU's, so the execute stage can mux either source into the same writeback and flag path.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_step.sv | 37 +++
 rtl/mdu_iter.sv | 132 +++++++++++++
 tb/tb_mdu_iter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [MDU_WIDTH-1:0] DIVZ_QUOT = '1;

    typedef enum logic [1:0] {
        MULLO = 2'b00,
        MULHU = 2'b01,
        DIVU  = 2'b10,
        REMU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring-divide step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    input  logic             is_div,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             qbit
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    always_comb begin
        // Divide: hi is the partial remainder, lo shifts the dividend out from the top.
        trial  = {hi, lo[WIDTH-1]};
        diff   = trial[WIDTH-1:0] - opnd;
        // Multiply: hi is the upper accumulator, lo shifts the multiplier out from the bottom.
        addend = lo[0] ? opnd : '0;
        sum    = {1'b0, hi} + {1'b0, addend};
        if (is_div) begin
            qbit    = (trial >= {1'b0, opnd});
            hi_next = qbit ? diff : trial[WIDTH-1:0];
            lo_next = lo;
        end else begin
            qbit    = 1'b0;
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative unsigned MUL/DIV unit with start/busy/done handshake; option MDU_EARLY_OUT_EN
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t       state;
    mdu_op_t          op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd, hi, lo;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_q, divz, is_div;
    logic [WIDTH-1:0] res_y;
    logic             res_v;

    assign is_div = op_q[1];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .is_div  (is_div),
        .hi_next (step_hi),
        .lo_next (step_lo),
        .qbit    (step_q)
    );

    // After WIDTH steps: hi:lo is the product, or hi = remainder and lo = quotient.
    always_comb begin
        res_y = lo;
        res_v = 1'b0;
        case (op_q)
            MULLO:   begin res_y = lo; res_v = |hi; end
            MULHU:   begin res_y = hi; res_v = 1'b0; end
            DIVU:    begin res_y = lo; res_v = divz; end
            default: begin res_y = hi; res_v = divz; end
        endcase
    end

`ifdef MDU_EARLY_OUT_EN
    logic             trivial;
    logic [WIDTH-1:0] triv_y;

    always_comb begin
        trivial = op[1] ? (B == '0) : ((A == '0) || (B == '0));
        case (mdu_op_t'(op))
            DIVU:    triv_y = WIDTH'(DIVZ_QUOT);
            REMU:    triv_y = A;
            default: triv_y = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= MULLO;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            divz  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Y     <= '0;
            z     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q <= mdu_op_t'(op);
                    opnd <= op[1] ? B : A;
                    hi   <= '0;
                    lo   <= op[1] ? A : B;
                    divz <= (B == '0);
                    cnt  <= '0;
                    busy <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                    if (trivial) begin
                        state <= DONE;
                        done  <= 1'b1;
                        Y     <= triv_y;
                        v     <= op[1];
                        z     <= (triv_y == '0);
                        n     <= triv_y[WIDTH-1];
                    end else begin
                        state <= RUN;
                    end
`else
                    state <= RUN;
`endif
                end
                RUN: if (cnt == CW'(WIDTH)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    Y     <= res_y;
                    v     <= res_v;
                    z     <= (res_y == '0);
                    n     <= res_y[WIDTH-1];
                end else begin
                    hi  <= step_hi;
                    lo  <= is_div ? {lo[WIDTH-2:0], step_q} : step_lo;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter: vector table, random ops vs. arithmetic model, corner sequences
module tb_mdu_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n, start;
    logic [1:0]    op;
    logic [W-1:0]  a, b, y;
    logic          busy, done, z, v, n;

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    mdu_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .Y       (y),
        .z       (z),
        .v       (v),
        .n       (n)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         z;
        logic         v;
        logic         nf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic and the divide-by-zero rules.
    function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           ov;
        p = 64'(aa) * 64'(bb);
        case (o)
            2'd0:    begin r = p[W-1:0];   ov = (p[2*W-1:W] != 0); end
            2'd1:    begin r = p[2*W-1:W]; ov = 1'b0; end
            2'd2:    begin r = (bb == 0) ? {W{1'b1}} : aa / bb; ov = (bb == 0); end
            default: begin r = (bb == 0) ? aa : aa % bb;        ov = (bb == 0); end
        endcase
        return {r, (r == 0), ov, r[W-1]};
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
`ifdef MDU_EARLY_OUT_EN
        if (o[1] ? (bb == 0) : (aa == 0 || bb == 0)) return 0;
`endif
        return W + 1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, output logic [W+2:0] res, output int lat);
        int d0;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {y, z, v, n};
        check({tag, " latency"}, 64'(lat), 64'(exp_lat(o, aa, bb)));
        @(posedge clk); #1;
        check({tag, " busy/done after"}, {busy, done}, 2'b00);
        check({tag, " Y held"}, 64'(y), 64'(res[W+2:3]));
        check({tag, " single done"}, 64'(done_cnt - d0), 64'd1);
    endtask

    vec_t         tbl[10];
    logic [W+2:0] res;
    int           lat, d0;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    initial begin
        tbl[0] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{2'd2, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'd3, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'd2, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{2'd3, 32'd5,         32'd0,         32'd5,         1'b0, 1'b1, 1'b0};
        tbl[7] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2'd3, 32'd0,         32'd0,         32'd0,         1'b1, 1'b1, 1'b0};
        tbl[9] = '{2'd0, 32'd0,         32'd12345,     32'd0,         1'b1, 1'b0, 1'b0};

        reset_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, y, z, v, n}, '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("vec%0d result", i), 64'(res), 64'({tbl[i].y, tbl[i].z, tbl[i].v, tbl[i].nf}));
        end

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = (i % 7 == 3) ? 32'($urandom_range(0, 50)) : $urandom;
            case (i % 5)
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb, res, lat);
            check($sformatf("rnd%0d op%0d %0h,%0h result", i, ro, ra, rb), 64'(res), 64'(model(ro, ra, rb)));
        end

        // start during RUN and operand changes must not disturb the running op
        d0 = done_cnt;
        @(negedge clk);
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4; end
            if (lat == 6) start = 1'b0;
            if (lat == 10) a = 32'd999;
        end
        check("ignore start latency", 64'(lat), 64'(W + 1));
        check("ignore start result", 64'({y, z, v, n}), 64'({32'd14, 1'b0, 1'b0, 1'b0}));
        repeat (40) @(posedge clk);
        #1;
        check("ignore start done count", 64'(done_cnt - d0), 64'd1);
        check("ignore start idle", 64'(busy), 64'd0);

        // reset mid-RUN abandons the op
        @(negedge clk);
        op = 2'd0; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        check("mid-run reset outputs", {busy, done, y, z, v, n}, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abandoned op no done", 64'(done_cnt - d0), 64'd0);
        check("abandoned op outputs", {busy, y, z, v, n}, '0);
        run_op("post-reset div", 2'd2, 32'd9, 32'd3, res, lat);
        check("post-reset div result", 64'(res), 64'({32'd3, 1'b0, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
